// File: rtl/apb_scaled_delayer.sv
// APB delay bridge: forwards master requests to a slave and holds back the
// response by the slave's wait-state count scaled by RATIO_NUM/RATIO_DEN,
// emulating a slave on a slower device clock. Supports an address window,
// a runtime bypass, saturating arithmetic and isolation of the slave (psel
// and penable are dropped) while the response is being held.
module apb_scaled_delayer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       CNT_W     = 32,
    parameter int unsigned       RATIO_NUM = 507701,
    parameter int unsigned       RATIO_DEN = 100000,
    parameter logic [ADDR_W-1:0] WIN_BASE  = '0,
    parameter logic [ADDR_W:0]   WIN_SIZE  = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_bypass,
    output logic                  busy,
    // master side
    input  logic [ADDR_W-1:0]     in_paddr,
    input  logic                  in_psel,
    input  logic                  in_penable,
    input  logic [2:0]            in_pprot,
    input  logic                  in_pwrite,
    input  logic [DATA_W-1:0]     in_pwdata,
    input  logic [DATA_W/8-1:0]   in_pstrb,
    output logic                  in_pready,
    output logic [DATA_W-1:0]     in_prdata,
    output logic                  in_pslverr,
    // slave side
    output logic [ADDR_W-1:0]     out_paddr,
    output logic                  out_psel,
    output logic                  out_penable,
    output logic [2:0]            out_pprot,
    output logic                  out_pwrite,
    output logic [DATA_W-1:0]     out_pwdata,
    output logic [DATA_W/8-1:0]   out_pstrb,
    input  logic                  out_pready,
    input  logic [DATA_W-1:0]     out_prdata,
    input  logic                  out_pslverr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PASS  = 3'd1,
        S_WAIT  = 3'd2,
        S_DELAY = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    // Ratio constants clamped into the counter range; comparisons against the
    // denominator are done at 64 bits so a huge RATIO_DEN cannot truncate.
    localparam logic [63:0]      CNT_MAX = (CNT_W >= 64) ? '1 : ((64'd1 << CNT_W) - 64'd1);
    localparam logic [63:0]      NUM_L   = (64'(RATIO_NUM) > CNT_MAX) ? CNT_MAX : 64'(RATIO_NUM);
    localparam logic [CNT_W-1:0] NUM_C   = NUM_L[CNT_W-1:0];
    localparam logic [63:0]      DEN_L   = 64'(RATIO_DEN);
    localparam logic [CNT_W-1:0] DEN_C   = DEN_L[CNT_W-1:0];
    localparam logic [ADDR_W:0]  WIN_LO  = {1'b0, WIN_BASE};
    localparam logic [ADDR_W:0]  WIN_HI  = WIN_LO + WIN_SIZE;

    state_e              state_q;
    logic [CNT_W-1:0]    acc_q;
    logic [CNT_W-1:0]    rem_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                slverr_q;

    logic [CNT_W:0]      acc_sum;
    logic [CNT_W-1:0]    acc_d;
    logic [CNT_W-1:0]    rem_init_d;
    logic [CNT_W-1:0]    rem_d;
    logic                win_hit;
    logic                xfer_done;

    // Request fields other than psel/penable go straight through.
    assign out_paddr  = in_paddr;
    assign out_pprot  = in_pprot;
    assign out_pwrite = in_pwrite;
    assign out_pwdata = in_pwdata;
    assign out_pstrb  = in_pstrb;

    // Window compare one bit wider than the address so base+size cannot wrap.
    assign win_hit   = (WIN_SIZE == '0) ||
                       (({1'b0, in_paddr} >= WIN_LO) && ({1'b0, in_paddr} < WIN_HI));
    assign xfer_done = out_psel & out_penable & out_pready;

    // Saturating accumulate and remainder steps.
    assign acc_sum    = {1'b0, acc_q} + {1'b0, NUM_C};
    assign acc_d      = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
    assign rem_init_d = acc_q - DEN_C;
    assign rem_d      = rem_q - DEN_C;

    assign busy = (state_q != S_IDLE);

    // Response mux and slave isolation decoded from the current state.
    always_comb begin
        in_pready   = 1'b0;
        in_prdata   = '0;
        in_pslverr  = 1'b0;
        out_psel    = in_psel;
        out_penable = in_penable;
        case (state_q)
            S_PASS: begin
                in_pready  = out_pready;
                in_prdata  = out_prdata;
                in_pslverr = out_pslverr;
            end
            S_DELAY: begin
                out_psel    = 1'b0;
                out_penable = 1'b0;
            end
            S_RESP: begin
                out_psel    = 1'b0;
                out_penable = 1'b0;
                in_pready   = 1'b1;
                in_prdata   = rdata_q;
                in_pslverr  = slverr_q;
            end
            default: ;
        endcase
    end

    // Transaction FSM: count slave waits, then burn scaled delay cycles.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            rem_q    <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_psel) begin
                        if (cfg_bypass || !win_hit) begin
                            state_q <= S_PASS;
                        end else begin
                            state_q <= S_WAIT;
                            acc_q   <= '0;
                        end
                    end
                end
                S_PASS: begin
                    if (xfer_done) state_q <= S_IDLE;
                end
                S_WAIT: begin
                    if (xfer_done) begin
                        rdata_q  <= out_prdata;
                        slverr_q <= out_pslverr;
                        if (64'(acc_q) < DEN_L) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_DELAY;
                            rem_q   <= rem_init_d;
                        end
                    end else if (out_psel && out_penable) begin
                        acc_q <= acc_d;
                    end
                end
                S_DELAY: begin
                    if (64'(rem_q) < DEN_L) state_q <= S_RESP;
                    else                    rem_q   <= rem_d;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_scaled_delayer.sv
// Bench for apb_scaled_delayer: three instances (default ratio, 5/1 with an
// address window, 8-bit counter at 200/1) driven by directed steps; expected
// responses and delay counts are queued when a transfer starts and compared
// when the master sees pready.
module tb_apb_scaled_delayer;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          delays;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_bypass;
    logic [31:0] in_paddr;
    logic [2:0]  in_psel;
    logic        in_penable;
    logic [2:0]  in_pprot;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    logic [2:0]  busy_w, in_pready_w, in_pslverr_w, out_psel_w, out_penable_w, out_pwrite_w;
    logic [31:0] in_prdata_w [3];
    logic [31:0] out_paddr_w [3];
    logic [31:0] out_pwdata_w[3];
    logic [2:0]  out_pprot_w [3];
    logic [3:0]  out_pstrb_w [3];

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clock = ~clock;

    apb_scaled_delayer u_def (
        .clock(clock), .reset(reset), .cfg_bypass(cfg_bypass), .busy(busy_w[0]),
        .in_paddr(in_paddr), .in_psel(in_psel[0]), .in_penable(in_penable), .in_pprot(in_pprot),
        .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
        .in_pready(in_pready_w[0]), .in_prdata(in_prdata_w[0]), .in_pslverr(in_pslverr_w[0]),
        .out_paddr(out_paddr_w[0]), .out_psel(out_psel_w[0]), .out_penable(out_penable_w[0]),
        .out_pprot(out_pprot_w[0]), .out_pwrite(out_pwrite_w[0]), .out_pwdata(out_pwdata_w[0]),
        .out_pstrb(out_pstrb_w[0]), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    apb_scaled_delayer #(
        .RATIO_NUM(5), .RATIO_DEN(1), .WIN_BASE(32'h0000_1000), .WIN_SIZE(33'h0_0000_0100)
    ) u_win (
        .clock(clock), .reset(reset), .cfg_bypass(cfg_bypass), .busy(busy_w[1]),
        .in_paddr(in_paddr), .in_psel(in_psel[1]), .in_penable(in_penable), .in_pprot(in_pprot),
        .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
        .in_pready(in_pready_w[1]), .in_prdata(in_prdata_w[1]), .in_pslverr(in_pslverr_w[1]),
        .out_paddr(out_paddr_w[1]), .out_psel(out_psel_w[1]), .out_penable(out_penable_w[1]),
        .out_pprot(out_pprot_w[1]), .out_pwrite(out_pwrite_w[1]), .out_pwdata(out_pwdata_w[1]),
        .out_pstrb(out_pstrb_w[1]), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    apb_scaled_delayer #(
        .CNT_W(8), .RATIO_NUM(200), .RATIO_DEN(1)
    ) u_sat (
        .clock(clock), .reset(reset), .cfg_bypass(cfg_bypass), .busy(busy_w[2]),
        .in_paddr(in_paddr), .in_psel(in_psel[2]), .in_penable(in_penable), .in_pprot(in_pprot),
        .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
        .in_pready(in_pready_w[2]), .in_prdata(in_prdata_w[2]), .in_pslverr(in_pslverr_w[2]),
        .out_paddr(out_paddr_w[2]), .out_psel(out_psel_w[2]), .out_penable(out_penable_w[2]),
        .out_pprot(out_pprot_w[2]), .out_pwrite(out_pwrite_w[2]), .out_pwdata(out_pwdata_w[2]),
        .out_pstrb(out_pstrb_w[2]), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference delay count: saturating sum of W ratio steps, floor-divided.
    function automatic int exp_delays(input int k, input int w);
        longint unsigned n, d, mx, acc;
        case (k)
            0:       begin n = 507701; d = 100000; mx = 64'hFFFF_FFFF; end
            1:       begin n = 5;      d = 1;      mx = 64'hFFFF_FFFF; end
            default: begin n = 200;    d = 1;      mx = 64'd255;       end
        endcase
        acc = 0;
        for (int i = 0; i < w; i++) begin
            acc = acc + n;
            if (acc > mx) acc = mx;
        end
        return int'(acc / d);
    endfunction

    // One transfer on instance k. Entered just after a posedge, returns at a
    // posedge with psel still high so a back-to-back setup may follow.
    task automatic do_xfer(input int k, input logic [31:0] addr, input logic wr,
                           input logic [31:0] data, input int w, input logic err,
                           input logic byp, input logic pass, input string tag);
        exp_t e;
        int   cyc;
        int   bad;
        logic got;
        #1;
        cfg_bypass  = byp;
        in_paddr    = addr;
        in_pwrite   = wr;
        in_pwdata   = data;
        in_psel     = '0;
        in_psel[k]  = 1'b1;
        in_penable  = 1'b0;
        out_pready  = 1'b0;
        out_prdata  = data;
        out_pslverr = err;
        if (!pass) sb.push_back('{rdata: data, err: err, delays: exp_delays(k, w)});
        @(posedge clock);
        #1;
        in_penable = 1'b1;
        cfg_bypass = ~byp;
        for (int i = 0; i < w; i++) begin
            @(posedge clock);
            #1;
        end
        out_pready = 1'b1;
        @(negedge clock);
        if (pass) begin
            check({tag, "_pass_pready"}, 64'(in_pready_w[k]), 64'd1);
            check({tag, "_pass_prdata"}, 64'(in_prdata_w[k]), 64'(data));
            check({tag, "_pass_pslverr"}, 64'(in_pslverr_w[k]), 64'(err));
        end else begin
            check({tag, "_held_pready"}, 64'(in_pready_w[k]), 64'd0);
        end
        @(posedge clock);
        if (!pass) begin
            #1;
            out_pready  = 1'b0;
            out_prdata  = 32'hDEAD_BEEF;
            out_pslverr = ~err;
            cyc = 0;
            bad = 0;
            got = 1'b0;
            while (!got && cyc < 400) begin
                @(negedge clock);
                cyc++;
                if (in_pready_w[k]) begin
                    got = 1'b1;
                end else begin
                    if (out_psel_w[k] || out_penable_w[k] || in_prdata_w[k] != '0 || in_pslverr_w[k])
                        bad++;
                    @(posedge clock);
                end
            end
            e = sb.pop_front();
            check({tag, "_resp_seen"}, 64'(got), 64'd1);
            check({tag, "_latency"}, 64'(cyc), 64'(e.delays + 1));
            check({tag, "_prdata"}, 64'(in_prdata_w[k]), 64'(e.rdata));
            check({tag, "_pslverr"}, 64'(in_pslverr_w[k]), 64'(e.err));
            check({tag, "_isolated"}, 64'(bad), 64'd0);
            check({tag, "_resp_psel"}, 64'(out_psel_w[k]), 64'd0);
            @(posedge clock);
        end
    endtask

    task automatic go_idle();
        #1;
        in_psel    = '0;
        in_penable = 1'b0;
        out_pready = 1'b0;
        cfg_bypass = 1'b0;
        @(posedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int late;
        reset       = 1'b1;
        cfg_bypass  = 1'b0;
        in_paddr    = 32'h55AA_1234;
        in_psel     = 3'b101;
        in_penable  = 1'b1;
        in_pprot    = 3'b010;
        in_pwrite   = 1'b1;
        in_pwdata   = 32'h0F0F_F0F0;
        in_pstrb    = 4'hA;
        out_pready  = 1'b0;
        out_prdata  = '0;
        out_pslverr = 1'b0;

        // Request pass-through while held in reset (state stays IDLE).
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            check("thru_paddr", 64'(out_paddr_w[k]), 64'h55AA_1234);
            check("thru_pwdata", 64'(out_pwdata_w[k]), 64'h0F0F_F0F0);
            check("thru_pprot", 64'(out_pprot_w[k]), 64'd2);
            check("thru_pstrb", 64'(out_pstrb_w[k]), 64'hA);
            check("thru_pwrite", 64'(out_pwrite_w[k]), 64'd1);
            check("thru_psel", 64'(out_psel_w[k]), 64'(in_psel[k]));
            check("thru_penable", 64'(out_penable_w[k]), 64'd1);
        end
        in_psel    = '0;
        in_penable = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            check("rst_busy", 64'(busy_w[k]), 64'd0);
            check("rst_pready", 64'(in_pready_w[k]), 64'd0);
            check("rst_prdata", 64'(in_prdata_w[k]), 64'd0);
            check("rst_pslverr", 64'(in_pslverr_w[k]), 64'd0);
        end
        @(posedge clock);

        // 5/1 ratio, read, two waits: ten delay cycles then the response.
        do_xfer(1, 32'h0000_1000, 1'b0, 32'hCAFE_0001, 2, 1'b0, 1'b0, 1'b0, "t1_n5");
        go_idle();
        // Default ratio, write, three waits: fifteen delay cycles.
        do_xfer(0, 32'h0000_0040, 1'b1, 32'h1234_5678, 3, 1'b0, 1'b0, 1'b0, "t2_def");
        go_idle();
        // Zero-wait slave with an error: registered response one cycle later.
        do_xfer(0, 32'h0000_0080, 1'b0, 32'h0000_A5A5, 0, 1'b1, 1'b0, 1'b0, "t3_w0");
        go_idle();

        // Bypass: combinational response, busy gone the next cycle.
        do_xfer(0, 32'h0000_0100, 1'b0, 32'hBEEF_0002, 2, 1'b0, 1'b1, 1'b1, "t4_byp");
        #1;
        in_psel = '0;
        @(negedge clock);
        check("t4_byp_busy_drop", 64'(busy_w[0]), 64'd0);
        go_idle();
        // Window edges on the windowed instance.
        do_xfer(1, 32'h0000_2000, 1'b0, 32'h2000_0003, 1, 1'b0, 1'b0, 1'b1, "t4_outwin");
        #1;
        in_psel = '0;
        @(negedge clock);
        check("t4_outwin_busy_drop", 64'(busy_w[1]), 64'd0);
        go_idle();
        do_xfer(1, 32'h0000_10FF, 1'b0, 32'h10FF_0004, 1, 1'b0, 1'b0, 1'b0, "t4_lastin");
        go_idle();
        do_xfer(1, 32'h0000_1100, 1'b0, 32'h1100_0005, 0, 1'b1, 1'b0, 1'b1, "t4_pastwin");
        go_idle();

        // 8-bit counter, 200/1, three waits: saturates at 255.
        do_xfer(2, 32'h0000_0000, 1'b0, 32'h5A7_0006, 3, 1'b0, 1'b0, 1'b0, "t5_sat");
        go_idle();

        // Reset in the middle of DELAY aborts silently.
        #1;
        in_paddr    = 32'h0000_1000;
        in_psel     = 3'b010;
        in_penable  = 1'b0;
        out_pready  = 1'b0;
        out_prdata  = 32'h0BAD_0BAD;
        out_pslverr = 1'b0;
        @(posedge clock);
        #1;
        in_penable = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        out_pready = 1'b1;
        @(posedge clock);
        #1;
        out_pready = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check("t6_in_delay_busy", 64'(busy_w[1]), 64'd1);
        check("t6_in_delay_psel", 64'(out_psel_w[1]), 64'd0);
        reset      = 1'b1;
        in_psel    = '0;
        in_penable = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("t6_rst_busy", 64'(busy_w[1]), 64'd0);
        check("t6_rst_pready", 64'(in_pready_w[1]), 64'd0);
        check("t6_rst_prdata", 64'(in_prdata_w[1]), 64'd0);
        check("t6_rst_pslverr", 64'(in_pslverr_w[1]), 64'd0);
        late = 0;
        repeat (12) begin
            @(negedge clock);
            if (in_pready_w[1] || busy_w[1]) late++;
        end
        check("t6_no_late_resp", 64'(late), 64'd0);
        @(posedge clock);
        // Back-to-back transfers: second setup in the cycle right after RESP.
        do_xfer(1, 32'h0000_1010, 1'b0, 32'hB2B0_0007, 1, 1'b0, 1'b0, 1'b0, "t6_b2b_a");
        do_xfer(1, 32'h0000_1020, 1'b1, 32'hB2B0_0008, 2, 1'b1, 1'b0, 1'b0, "t6_b2b_b");
        go_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
